// File: rtl/barrel_shifter.sv
// Registered barrel shifter: logical shift or rotate, either direction.
// Left moves reuse the right-moving network by bit-reversing the operand on
// the way in and the result on the way out. Each network stage moves by a
// fixed power of two.

// One network stage: move right by SHIFT when i_en is set. The vacated MSBs
// take the wrapped LSBs for a rotate and zeros for a logical shift.
module barrel_shifter_stage #(
  parameter int WIDTH = 4,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en,
  input  logic             i_rot,
  output logic [WIDTH-1:0] o_d
);
  logic [WIDTH-1:0] w_moved;
  logic [WIDTH-1:0] w_wrap;

  assign w_moved = i_d >> SHIFT;
  assign w_wrap  = i_d << (WIDTH - SHIFT);

  // Bypass, or move with the fill chosen by the mode.
  always_comb begin
    o_d = i_d;
    if (i_en) o_d = w_moved | (i_rot ? w_wrap : '0);
  end
endmodule

module barrel_shifter #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             select,
  input  logic             direction,
  input  logic [SHW-1:0]   shift_value,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid
);
  logic [WIDTH-1:0]          w_din_rev;
  logic [WIDTH-1:0]          w_res_rev;
  logic [WIDTH-1:0]          w_res;
  logic [SHW:0][WIDTH-1:0]   w_stg;
  logic [WIDTH-1:0]          r_dout;
  logic                      r_vld;

  // Bit-reverse the operand so that left moves can use the right network.
  always_comb begin
    w_din_rev = '0;
    for (int i = 0; i < WIDTH; i++) w_din_rev[i] = din[WIDTH-1-i];
  end

  assign w_stg[0] = direction ? w_din_rev : din;

  genvar k;
  generate
    for (k = 0; k < SHW; k++) begin : g_stg
      barrel_shifter_stage #(
        .WIDTH (WIDTH),
        .SHIFT (1 << k)
      ) u_stg (
        .i_d   (w_stg[k]),
        .i_en  (shift_value[k]),
        .i_rot (select),
        .o_d   (w_stg[k+1])
      );
    end
  endgenerate

  // Undo the input reversal for left moves.
  always_comb begin
    w_res_rev = '0;
    for (int i = 0; i < WIDTH; i++) w_res_rev[i] = w_stg[SHW][WIDTH-1-i];
  end

  assign w_res = direction ? w_res_rev : w_stg[SHW];

  // Capture a result on each valid input; hold dout otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) r_dout <= w_res;
    end
  end

  assign dout      = r_dout;
  assign out_valid = r_vld;
endmodule

// File: tb/tb_barrel_shifter.sv
// Bench for barrel_shifter (WIDTH=4): directed vectors, hold, mid-stream
// reset and a randomized back-to-back run against an index-formula model.
module tb_barrel_shifter;
  localparam int W  = 4;
  localparam int SW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          select;
  logic          direction;
  logic [SW-1:0] shift_value;
  logic [W-1:0]  din;
  logic          in_valid;
  logic [W-1:0]  dout;
  logic          out_valid;

  int total = 0;
  int bad   = 0;

  barrel_shifter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .select      (select),
    .direction   (direction),
    .shift_value (shift_value),
    .din         (din),
    .in_valid    (in_valid),
    .dout        (dout),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: bit-index definitions for rotates, plain arithmetic for shifts.
  function automatic logic [W-1:0] model(input logic sel, input logic dir,
                                         input int s, input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    if (sel) begin
      for (int i = 0; i < W; i++)
        r[i] = dir ? d[(i - s + W) % W] : d[(i + s) % W];
    end else begin
      r = dir ? W'(d << s) : W'(d >> s);
    end
    return r;
  endfunction

  function automatic int popc(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  // Drive one valid operation and check it one edge later.
  task automatic op(input string tag, input logic sel, input logic dir,
                    input int s, input logic [W-1:0] d, input logic [W-1:0] exp);
    select = sel; direction = dir; shift_value = SW'(s); din = d; in_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_dout"}, 32'(dout), 32'(exp));
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  logic [W-1:0] d_r, e_r;
  int           s_r;
  logic         sel_r, dir_r;

  initial begin
    rst_n = 1'b0; select = 1'b0; direction = 1'b0; shift_value = '0;
    din = '0; in_valid = 1'b0;
    #12;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    op("lsr1", 0, 0, 1, 4'b1000, 4'b0100);
    op("lsr2", 0, 0, 2, 4'b1000, 4'b0010);
    op("lsr3", 0, 0, 3, 4'b1000, 4'b0001);
    op("ror1", 1, 0, 1, 4'b1011, 4'b1101);
    op("ror2", 1, 0, 2, 4'b1011, 4'b1110);
    op("ror3", 1, 0, 3, 4'b1011, 4'b0111);
    op("lsl1", 0, 1, 1, 4'b0001, 4'b0010);
    op("lsl2", 0, 1, 2, 4'b0001, 4'b0100);
    op("lsl3", 0, 1, 3, 4'b0001, 4'b1000);
    op("rol1", 1, 1, 1, 4'b1011, 4'b0111);
    op("rol2", 1, 1, 2, 4'b1011, 4'b1110);
    op("rol3", 1, 1, 3, 4'b1011, 4'b1101);
    op("pass_lsr", 0, 0, 0, 4'b1011, 4'b1011);
    op("pass_lsl", 0, 1, 0, 4'b1011, 4'b1011);
    op("pass_ror", 1, 0, 0, 4'b1011, 4'b1011);
    op("pass_rol", 1, 1, 0, 4'b1011, 4'b1011);

    // Hold: idle cycles keep dout, drop out_valid, even if operands change.
    in_valid = 1'b0; din = 4'b0110; shift_value = 2'd1;
    @(posedge clk); #1;
    chk("hold_dout", 32'(dout), 32'b1011);
    chk("hold_vld", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("hold2_dout", 32'(dout), 32'b1011);

    // Mid-stream reset: back-to-back traffic, then reset between edges.
    op("pre_rst0", 0, 0, 1, 4'b1110, 4'b0111);
    op("pre_rst1", 1, 1, 1, 4'b1001, 4'b0011);
    select = 1'b1; direction = 1'b0; shift_value = 2'd2; din = 4'b0110; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_dout", 32'(dout), 32'd0);
    chk("mrst_vld", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("mrst_edge_dout", 32'(dout), 32'd0);
    chk("mrst_edge_vld", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle_vld", 32'(out_valid), 32'd0);
    chk("post_rst_idle_dout", 32'(dout), 32'd0);
    op("post_rst", 1, 0, 1, 4'b0011, 4'b1001);

    // Randomized back-to-back run.
    for (int n = 0; n < 300; n++) begin
      sel_r = 1'($urandom); dir_r = 1'($urandom);
      s_r = int'($urandom_range(0, W-1)); d_r = W'($urandom);
      e_r = model(sel_r, dir_r, s_r, d_r);
      op("rnd", sel_r, dir_r, s_r, d_r, e_r);
      if (sel_r) chk("rnd_popc", 32'(popc(dout)), 32'(popc(d_r)));
      if (!sel_r && s_r == W-1)
        chk("rnd_edge", 32'(dout), dir_r ? 32'({d_r[0], 3'b000}) : 32'({3'b000, d_r[W-1]}));
    end

    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("end_vld", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
